dmem_arbiter: RTL and testbench



---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 tb/tb_dmem_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : dmem_arb_pkg                                              |
// | Brief  : Shared types and defaults for the data-RAM arbiter.       |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } owner_t;

    localparam int unsigned c_MAX_BURST = 4;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : dmem_arbiter                                              |
// | Brief  : Registered two-port arbiter in front of a single-port     |
// |          asynchronous-read data RAM, with a burst-limited streak.  |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int N         = 1024,
    parameter int DW        = 32,
    parameter int MAX_BURST = c_MAX_BURST
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [$clog2(N)-1:0] a_addr,
    input  logic [DW-1:0]        a_wdata,
    output logic                 a_gnt,
    output logic [DW-1:0]        a_rdata,
    output logic                 a_rvalid,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [$clog2(N)-1:0] b_addr,
    input  logic [DW-1:0]        b_wdata,
    output logic                 b_gnt,
    output logic [DW-1:0]        b_rdata,
    output logic                 b_rvalid,
    output logic [$clog2(N)-1:0] ram_addr,
    output logic                 ram_we,
    output logic [DW-1:0]        ram_wdata,
    input  logic [DW-1:0]        ram_rdata,
    output logic [1:0]           owner
);

    localparam int AW = $clog2(N);
    localparam int SW = $clog2(MAX_BURST + 1);
    localparam logic [SW-1:0] c_BURST_LIM = SW'(MAX_BURST);

    owner_t        r_state;
    owner_t        w_state_next;
    logic [SW-1:0] r_streak;
    logic [SW-1:0] w_streak_run;
    logic [SW-1:0] w_streak_next;

    logic [1:0]    w_req;
    logic [1:0]    w_we;
    logic [1:0]    w_gnt;
    logic          w_oth_req;
    logic [DW-1:0] r_rdata  [2];
    logic [1:0]    r_rvalid;

    assign w_req = {b_req, a_req};
    assign w_we  = {b_we,  a_we};

    // Reset gates the grants so no write can slip out during the reset cycle.
    assign w_gnt[0] = (r_state == OWN_A) & a_req & ~RST;
    assign w_gnt[1] = (r_state == OWN_B) & b_req & ~RST;

    assign w_oth_req = (r_state == OWN_B) ? w_req[0] : w_req[1];

    always_comb begin
        w_state_next = r_state;
        w_streak_run = r_streak;
        if (!w_oth_req) begin
            w_streak_run = '0;
        end else if (|w_gnt) begin
            w_streak_run = r_streak + SW'(1);
        end

        case (r_state)
            IDLE: begin
                if (a_req)      w_state_next = OWN_A;
                else if (b_req) w_state_next = OWN_B;
                else            w_state_next = IDLE;
            end
            OWN_A: begin
                if (b_req && (!a_req || w_streak_run >= c_BURST_LIM)) w_state_next = OWN_B;
                else if (a_req)                                       w_state_next = OWN_A;
                else                                                  w_state_next = IDLE;
            end
            OWN_B: begin
                if (a_req && (!b_req || w_streak_run >= c_BURST_LIM)) w_state_next = OWN_A;
                else if (b_req)                                       w_state_next = OWN_B;
                else                                                  w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase

        w_streak_next = (w_state_next != r_state) ? '0 : w_streak_run;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_streak <= '0;
        end else begin
            r_state  <= w_state_next;
            r_streak <= w_streak_next;
        end
    end

    // Read data is captured at the grant edge and held until the next read grant.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rvalid   <= '0;
            r_rdata[0] <= '0;
            r_rdata[1] <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                r_rvalid[p] <= w_gnt[p] & ~w_we[p];
                if (w_gnt[p] && !w_we[p]) begin
                    r_rdata[p] <= ram_rdata;
                end
            end
        end
    end

    assign a_gnt     = w_gnt[0];
    assign b_gnt     = w_gnt[1];
    assign a_rdata   = r_rdata[0];
    assign b_rdata   = r_rdata[1];
    assign a_rvalid  = r_rvalid[0];
    assign b_rvalid  = r_rvalid[1];

    assign ram_addr  = (r_state == OWN_B) ? b_addr  : a_addr;
    assign ram_wdata = (r_state == OWN_B) ? b_wdata : a_wdata;
    assign ram_we    = |(w_gnt & w_we);
    assign owner     = r_state;

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_dmem_arbiter                                           |
// | Brief  : Directed and randomised bench for dmem_arbiter against a  |
// |          transaction-level model of the two-port RAM arbiter.      |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_dmem_arbiter;

    localparam int N  = 1024;
    localparam int DW = 32;
    localparam int MB = 4;
    localparam int AW = 10;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid, ram_we;
    logic [DW-1:0] a_rdata, b_rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;
    logic [1:0]    owner;

    dmem_arbiter #(.N(N), .DW(DW), .MAX_BURST(MB)) dut (
        .CLK(CLK), .RST(RST),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .owner(owner)
    );

    always #5 CLK = ~CLK;

    // Asynchronous-read, synchronous-write RAM, preloaded at the first edge.
    logic [DW-1:0] ram [N];
    logic          ram_init_done = 1'b0;
    always @(posedge CLK) begin
        if (!ram_init_done) begin
            for (int i = 0; i < N; i++) ram[i] <= 32'(i) * 32'h9E3779B9;
            ram_init_done <= 1'b1;
        end else if (ram_we) begin
            ram[ram_addr] <= ram_wdata;
        end
    end
    assign ram_rdata = ram[ram_addr];

    // Model state: owner 0=none, 1=A, 2=B; run = grants to owner while other waits.
    int            m_owner = 0;
    int            m_run   = 0;
    logic [DW-1:0] m_mem [N];
    logic [DW-1:0] m_rdata [2];
    bit            m_rv [2];
    bit            m_known = 0;
    bit            m_last_gnt [2];

    bit            o_gnt [2];
    bit            o_we;
    bit            o_rv [2];
    logic [DW-1:0] o_rd [2];
    logic [1:0]    o_owner;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%h, expected 0x%h", nm, $time, act, exp);
        end
    endtask

    // Called just after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic tick(input bit r);
        bit            rq [2];
        bit            wq [2];
        logic [AW-1:0] ad [2];
        logic [DW-1:0] wd [2];
        bit            eg [2];
        bit            ewe;
        int            me, oth, run;
        RST = r;
        #2;
        rq[0] = a_req; rq[1] = b_req; wq[0] = a_we; wq[1] = b_we;
        ad[0] = a_addr; ad[1] = b_addr; wd[0] = a_wdata; wd[1] = b_wdata;
        eg[0] = !r && m_owner == 1 && rq[0];
        eg[1] = !r && m_owner == 2 && rq[1];
        ewe   = (eg[0] && wq[0]) || (eg[1] && wq[1]);

        o_gnt[0] = a_gnt; o_gnt[1] = b_gnt; o_we = ram_we;
        o_rv[0] = a_rvalid; o_rv[1] = b_rvalid; o_rd[0] = a_rdata; o_rd[1] = b_rdata;
        o_owner = owner;

        chk("a_gnt", 32'(a_gnt), 32'(eg[0]));
        chk("b_gnt", 32'(b_gnt), 32'(eg[1]));
        chk("ram_we", 32'(ram_we), 32'(ewe));
        if (m_known) begin
            chk("owner", 32'(owner), 32'(m_owner));
            chk("ram_addr", 32'(ram_addr), 32'(m_owner == 2 ? ad[1] : ad[0]));
            chk("ram_wdata", ram_wdata, m_owner == 2 ? wd[1] : wd[0]);
            chk("a_rvalid", 32'(a_rvalid), 32'(m_rv[0]));
            chk("b_rvalid", 32'(b_rvalid), 32'(m_rv[1]));
            chk("a_rdata", a_rdata, m_rdata[0]);
            chk("b_rdata", b_rdata, m_rdata[1]);
        end
        m_last_gnt = eg;

        if (r) begin
            m_owner = 0; m_run = 0; m_known = 1;
            for (int p = 0; p < 2; p++) begin m_rdata[p] = '0; m_rv[p] = 0; end
        end else begin
            for (int p = 0; p < 2; p++) begin
                m_rv[p] = eg[p] && !wq[p];
                if (eg[p] && !wq[p]) m_rdata[p] = m_mem[ad[p]];
                if (eg[p] && wq[p])  m_mem[ad[p]] = wd[p];
            end
            if (m_owner == 0) begin
                m_owner = rq[0] ? 1 : (rq[1] ? 2 : 0);
                m_run   = 0;
            end else begin
                me  = m_owner - 1;
                oth = 1 - me;
                run = rq[oth] ? m_run + (eg[me] ? 1 : 0) : 0;
                if (rq[oth] && (!rq[me] || run >= MB)) begin
                    m_owner = oth + 1; m_run = 0;
                end else if (rq[me]) begin
                    m_run = run;
                end else begin
                    m_owner = 0; m_run = 0;
                end
            end
        end
        @(negedge CLK);
    endtask

    bit            pend [2];
    bit            p_we [2];
    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_data [2];
    logic [DW-1:0] old_val;

    initial begin
        for (int i = 0; i < N; i++) m_mem[i] = 32'(i) * 32'h9E3779B9;

        // Reset held two cycles with a write request pending.
        a_req = 1; a_we = 1; a_addr = 10'd3; a_wdata = 32'h11111111;
        tick(1);
        chk("rst_we0", 32'(o_we), 32'd0);
        tick(1);
        chk("rst_we1", 32'(o_we), 32'd0);
        a_req = 0; a_we = 0;
        tick(0);
        chk("rst_owner", 32'(o_owner), 32'd0);
        chk("rst_rvalid", 32'(o_rv[0]), 32'd0);

        // Single write then read on port A.
        a_req = 1; a_we = 1; a_addr = 10'd5; a_wdata = 32'hDEADBEEF;
        tick(0);
        chk("wr_latency", 32'(o_gnt[0]), 32'd0);
        tick(0);
        chk("wr_gnt", 32'(o_gnt[0]), 32'd1);
        chk("wr_ram_we", 32'(o_we), 32'd1);
        a_we = 0;
        tick(0);
        chk("rd_gnt", 32'(o_gnt[0]), 32'd1);
        a_req = 0;
        tick(0);
        chk("rd_rvalid", 32'(o_rv[0]), 32'd1);
        chk("rd_data", o_rd[0], 32'hDEADBEEF);
        tick(0);
        chk("rd_rvalid_off", 32'(o_rv[0]), 32'd0);

        // Back-to-back stream of eight reads on A.
        a_req = 1; a_we = 0; a_addr = 10'd0;
        tick(0);
        chk("stream_latency", 32'(o_gnt[0]), 32'd0);
        for (int i = 0; i < 8; i++) begin
            a_addr = AW'(i);
            tick(0);
            chk("stream_gnt", 32'(o_gnt[0]), 32'd1);
            chk("stream_owner", 32'(o_owner), 32'd1);
        end
        a_req = 0;
        tick(0); tick(0);

        // Continuous contention from idle: A x4, B x4, A.
        a_req = 1; b_req = 1; a_we = 0; b_we = 0; a_addr = 10'd1; b_addr = 10'd2;
        tick(0);
        for (int i = 0; i < 9; i++) begin
            tick(0);
            chk("cont_a", 32'(o_gnt[0]), 32'((i < 4) || (i == 8)));
            chk("cont_b", 32'(o_gnt[1]), 32'((i >= 4) && (i < 8)));
        end
        a_req = 0; b_req = 0;
        tick(0); tick(0);

        // Cross-port coherence: B writes, A reads back.
        b_req = 1; b_we = 1; b_addr = 10'd100; b_wdata = 32'h12345678;
        tick(0);
        tick(0);
        chk("x_b_gnt", 32'(o_gnt[1]), 32'd1);
        b_req = 0; b_we = 0;
        tick(0);
        a_req = 1; a_we = 0; a_addr = 10'd100;
        tick(0);
        tick(0);
        chk("x_a_gnt", 32'(o_gnt[0]), 32'd1);
        a_req = 0;
        tick(0);
        chk("x_rdata", o_rd[0], 32'h12345678);
        tick(0);

        // Reset asserted in the cycle B's write would be granted.
        old_val = ram[200];
        b_req = 1; b_we = 1; b_addr = 10'd200; b_wdata = 32'hCAFEF00D;
        tick(0);
        tick(1);
        chk("rstmid_b_gnt", 32'(o_gnt[1]), 32'd0);
        chk("rstmid_we", 32'(o_we), 32'd0);
        b_req = 0; b_we = 0;
        tick(0);
        chk("rstmid_owner", 32'(o_owner), 32'd0);
        chk("rstmid_mem", ram[200], old_val);

        // Randomised traffic with occasional resets.
        for (int p = 0; p < 2; p++) pend[p] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && ($urandom % 100) < 55) begin
                    pend[p]   = 1;
                    p_we[p]   = 1'($urandom % 2);
                    p_addr[p] = AW'($urandom % 16);
                    p_data[p] = $urandom;
                end
            end
            a_req = pend[0]; a_we = p_we[0]; a_addr = p_addr[0]; a_wdata = p_data[0];
            b_req = pend[1]; b_we = p_we[1]; b_addr = p_addr[1]; b_wdata = p_data[1];
            tick(($urandom % 200) == 0);
            for (int p = 0; p < 2; p++) if (m_last_gnt[p]) pend[p] = 0;
        end
        a_req = 0; b_req = 0;
        tick(0); tick(0); tick(0);
        for (int i = 0; i < 16; i++) chk("mem_final", ram[i], m_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire
